writeback_buffer: RTL and testbench
===================================

Name: writeback_buffer

Overview:
- Parametrised dirty-line write-back buffer between the dcache miss path and the AXI write channel of `AXI_Bus_Interface`.
- Generalises the fixed 128-bit, single-outstanding `wr_req/wr_addr/wr_data` path to LINE_WORDS-wide lines and DEPTH queued victims.
- Adds same-line coalescing and read-forwarding, so the dcache can refill a line that is still queued without a stale AXI read.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; line width LW = 32*LINE_WORDS.
- DEPTH, 4, number of buffered lines; must be a power of two, at least 2.
- OFFSET_W, 4, byte-offset bits dropped for line alignment; equals log2(4*LINE_WORDS).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push_valid  in  1  dcache offers a dirty victim line.
- push_ready  out  1  buffer can accept a line this cycle.
- push_addr  in  32  victim line address; bits [OFFSET_W-1:0] are ignored.
- push_data  in  LW  victim line data, word 0 in the LSBs.
- lookup_addr  in  32  refill address being checked by the dcache.
- lookup_hit  out  1  a matching line is queued.
- lookup_data  out  LW  data of the youngest matching entry.
- wr_req  out  1  write request to the AXI slave.
- wr_addr  out  32  line-aligned write address (low OFFSET_W bits are 0).
- wr_data  out  LW  line data.
- wr_rdy  in  1  AXI slave accepts the request.
- wr_valid  in  1  AXI slave reports the write is complete.
- empty  out  1  no entries are held, including any in flight.
- count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: circular queue with head/tail pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
  - Each entry holds {valid, tag = addr[31:OFFSET_W], data}.
- Reset: all valid bits cleared, head = tail = 0, FSM = IDLE, wr_req = 0, wr_addr = 0, wr_data = 0, lookup_hit = 0, push_ready = 1, empty = 1, count = 0.
  - Reset mid-transfer abandons the in-flight write; the AXI side is reset by the same rst.
- push_ready = (count != DEPTH), registered-state based only. A pop in the same cycle never frees a slot for that cycle's push.
- Push takes effect when push_valid and push_ready are both high at the edge.
  - Coalesce: if a valid entry that is not the in-flight head has the same tag, its data is overwritten in place; count and tail are unchanged.
  - Otherwise the line is written at tail, then tail++ and count++.
  - The buffer never holds two non-in-flight entries with the same tag.
- Lookup is combinational over all valid entries.
  - On multiple matches (in-flight head plus a newer copy), the newer entry wins.
  - When there is no hit, lookup_data is don't-care and the bench must not check it.
- Drain FSM:
  - IDLE: if count > 0, go to REQ and drive wr_req, wr_addr and wr_data from the head on the next cycle.
  - REQ: wr_req = 1; wr_addr and wr_data stay stable until wr_rdy is sampled high, then go to WAIT with wr_req = 0.
  - WAIT: on wr_valid, invalidate the head, head++, count--. Go to REQ if the remaining count > 0, otherwise to IDLE.
  - Minimum latency from push to wr_req is 2 cycles.
  - The head entry is locked from the REQ cycle until its pop.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged, and both pointers advance.
  - A push matching the in-flight head tag appends a new entry; the old data still completes on AXI.
  - A wr_valid that arrives while not in WAIT is ignored.
- The counter never overflows or underflows. Assertions check: a push while full never happens, and a pop while empty never happens.

Decomposition:
- The shared cache defines package holds:
  - the WB state enum {WB_IDLE, WB_REQ, WB_WAIT};
  - the `wb_entry_t` struct;
  - the LINE_WORDS/OFFSET_W defaults, consistent with the existing TAGBITNUM/INDEXBITNUM/OFFSETNUM defines.
- One sub-module, `wb_match`: a combinational parallel tag compare with youngest-first priority select. It is parametrised by DEPTH and returns the hit flag and the selected index.

Test Plan:
- Reset with rst=1 for 2 cycles → all outputs at reset values; push_ready=1, count=0.
- Push 0x1000_0040 with data 0x…DEAD, wr_rdy=1 held, wr_valid pulsed 3 cycles after acceptance → wr_req rises 2 cycles after the push with wr_addr=0x1000_0040; count goes 1→0 and empty=1 after wr_valid.
- Push 4 lines (0x100, 0x200, 0x300, 0x400) with wr_rdy=0 → push_ready=0 and count=4; a 5th push_valid is not accepted; wr_addr stays 0x100. Raise wr_rdy and then wr_valid → FIFO drain order is 0x100, 0x200, 0x300, 0x400.
- Push 0x200 data A, then 0x300, then 0x200 data B while 0x100 is in flight → count=3 (coalesced), lookup_addr=0x204 gives hit=1 with data B, and AXI later writes 0x200 with B.
- While 0x100 is in WAIT, push 0x100 with new data C → count becomes 2, lookup returns C; after wr_valid, a second write of 0x100 with C is issued.
- Assert rst in WAIT with count=3 → next cycle wr_req=0, empty=1, lookup_hit=0, and a later wr_valid pulse has no effect.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// writeback_buffer_pkg: shared defaults, drain states and entry type for the dcache write-back buffer
package writeback_buffer_pkg;
    localparam int WB_LINE_WORDS = 4;
    localparam int WB_OFFSET_W   = 4;
    localparam int WB_TAG_W      = 32 - WB_OFFSET_W;
    localparam int WB_LW         = 32 * WB_LINE_WORDS;

    typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_WAIT} wb_state_e;

    typedef struct packed {
        logic                valid;
        logic [WB_TAG_W-1:0] tag;
        logic [WB_LW-1:0]    data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: dcache push/lookup, AXI write and status signals of the write-back buffer
interface writeback_buffer_if
    import writeback_buffer_pkg::*;
#(
    parameter int LINE_WORDS = WB_LINE_WORDS,
    parameter int DEPTH      = 4
);
    localparam int LW = 32 * LINE_WORDS;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_addr;
    logic [LW-1:0] push_data;
    logic [31:0]   lookup_addr;
    logic          lookup_hit;
    logic [LW-1:0] lookup_data;
    logic          wr_req;
    logic [31:0]   wr_addr;
    logic [LW-1:0] wr_data;
    logic          wr_rdy;
    logic          wr_valid;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        input  push_valid, push_addr, push_data, lookup_addr, wr_rdy, wr_valid,
        output push_ready, lookup_hit, lookup_data, wr_req, wr_addr, wr_data, empty, count
    );

    modport slave (
        output push_valid, push_addr, push_data, lookup_addr, wr_rdy, wr_valid,
        input  push_ready, lookup_hit, lookup_data, wr_req, wr_addr, wr_data, empty, count
    );
endinterface

// File: rtl/writeback_buffer_wb_match.sv
// wb_match: parallel tag compare over the queue; scanning oldest to youngest lets the youngest hit win
module wb_match #(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 28,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [TAG_W-1:0] tags [DEPTH],
    input  logic [TAG_W-1:0] key,
    input  logic [PW-1:0]    head,
    output logic             hit,
    output logic [PW-1:0]    idx
);
    logic [PW-1:0] slot;

    always_comb begin
        hit  = 1'b0;
        idx  = head;
        slot = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (valid[slot] && tags[slot] == key) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end
endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: queued dirty-line write-back with same-line coalescing and refill forwarding
module writeback_buffer
    import writeback_buffer_pkg::*;
#(
    parameter int LINE_WORDS = WB_LINE_WORDS,
    parameter int DEPTH      = 4,
    parameter int OFFSET_W   = WB_OFFSET_W
) (
    input logic               clk,
    input logic               rst,
    writeback_buffer_if.master bus
);
    localparam int LW    = 32 * LINE_WORDS;
    localparam int TAG_W = 32 - OFFSET_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [LW-1:0]    data_q [DEPTH];
    logic [LW-1:0]    data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    wb_state_e        state_q, state_d;
    logic             wr_req_q, wr_req_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [LW-1:0]    wr_data_q, wr_data_d;

    logic [TAG_W-1:0] push_tag, lookup_tag;
    logic [DEPTH-1:0] co_valid;
    logic             locked, co_hit, lk_hit, push_fire, pop;
    logic [PW-1:0]    co_idx, lk_idx, wr_slot, head_nxt;

    assign push_tag   = bus.push_addr[31:OFFSET_W];
    assign lookup_tag = bus.lookup_addr[31:OFFSET_W];
    assign locked     = state_q != WB_IDLE;
    // the in-flight head must keep its data, so it is hidden from coalescing
    assign co_valid   = valid_q & ~(DEPTH'(locked) << head_q);

    wb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_coalesce (
        .valid(co_valid), .tags(tag_q), .key(push_tag), .head(head_q), .hit(co_hit), .idx(co_idx)
    );

    wb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup (
        .valid(valid_q), .tags(tag_q), .key(lookup_tag), .head(head_q), .hit(lk_hit), .idx(lk_idx)
    );

    assign bus.push_ready  = count_q != CW'(DEPTH);
    assign push_fire       = bus.push_valid && bus.push_ready;
    assign pop             = state_q == WB_WAIT && bus.wr_valid;
    assign wr_slot         = co_hit ? co_idx : tail_q;
    assign head_nxt        = head_q + PW'(pop);
    assign bus.lookup_hit  = lk_hit;
    assign bus.lookup_data = data_q[lk_idx];
    assign bus.wr_req      = wr_req_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.empty       = count_q == '0;
    assign bus.count       = count_q;

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        head_d    = head_nxt;
        tail_d    = tail_q;
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop) valid_d[head_q] = 1'b0;
        if (push_fire) begin
            valid_d[wr_slot] = 1'b1;
            tag_d[wr_slot]   = push_tag;
            data_d[wr_slot]  = bus.push_data;
            tail_d           = tail_q + PW'(!co_hit);
        end
        count_d = count_q + CW'(push_fire && !co_hit) - CW'(pop);
        // loading from the _d view forwards a same-cycle push into the line about to be sent
        if ((state_q == WB_IDLE && count_q != '0) || (pop && count_d != '0)) begin
            state_d   = WB_REQ;
            wr_req_d  = 1'b1;
            wr_addr_d = {tag_d[head_nxt], {OFFSET_W{1'b0}}};
            wr_data_d = data_d[head_nxt];
        end else if (state_q == WB_REQ && bus.wr_rdy) begin
            state_d  = WB_WAIT;
            wr_req_d = 1'b0;
        end else if (pop) begin
            state_d = WB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= WB_IDLE;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assert property (@(posedge clk) disable iff (rst) !(push_fire && count_q == CW'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed and random checks of writeback_buffer against a line-queue model
module tb_writeback_buffer;
    import writeback_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int LW    = 32 * WB_LINE_WORDS;
    localparam int OW    = WB_OFFSET_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_buffer_if #(.LINE_WORDS(WB_LINE_WORDS), .DEPTH(DEPTH)) bus ();

    writeback_buffer #(.LINE_WORDS(WB_LINE_WORDS), .DEPTH(DEPTH), .OFFSET_W(OW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // oldest first: q[0] is the next line AXI will see
    wb_entry_t q[$];
    bit req_exp, waiting;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'h8000_0000 | (32'($urandom_range(0, 5)) << OW) | 32'($urandom_range(0, 15));
    endfunction

    task automatic check_outputs(input logic [31:0] la);
        bit hit = 1'b0;
        logic [LW-1:0] hd = '0;
        foreach (q[i]) if (q[i].tag == la[31:OW]) begin
            hit = 1'b1;
            hd  = q[i].data;
        end
        chk("count", LW'(bus.count), LW'(q.size()));
        chk("empty", LW'(bus.empty), LW'(q.size() == 0));
        chk("push_ready", LW'(bus.push_ready), LW'(q.size() != DEPTH));
        chk("lookup_hit", LW'(bus.lookup_hit), LW'(hit));
        if (hit) chk("lookup_data", bus.lookup_data, hd);
        chk("wr_req", LW'(bus.wr_req), LW'(req_exp));
        if (req_exp && q.size() > 0) begin
            chk("wr_addr", LW'(bus.wr_addr), LW'({q[0].tag, {OW{1'b0}}}));
            chk("wr_data", bus.wr_data, q[0].data);
        end
    endtask

    task automatic step(input bit pv, input logic [31:0] pa, input logic [LW-1:0] pd,
                        input bit rdy, input bit vld, input logic [31:0] la);
        bit fire, pop, locked;
        int hit_i, size_before;
        bus.push_valid  = pv;
        bus.push_addr   = pa;
        bus.push_data   = pd;
        bus.wr_rdy      = rdy;
        bus.wr_valid    = vld;
        bus.lookup_addr = la;
        #1;
        check_outputs(la);
        locked      = req_exp || waiting;
        fire        = pv && q.size() != DEPTH;
        pop         = waiting && vld;
        size_before = q.size();
        @(posedge clk);
        #1;
        if (fire) begin
            hit_i = -1;
            foreach (q[i]) if (q[i].tag == pa[31:OW] && !(locked && i == 0)) hit_i = i;
            if (hit_i >= 0) q[hit_i].data = pd;
            else q.push_back('{valid: 1'b1, tag: pa[31:OW], data: pd});
        end
        if (pop) begin
            q.delete(0);
            waiting = 1'b0;
            req_exp = q.size() > 0;
        end else if (req_exp && rdy) begin
            req_exp = 1'b0;
            waiting = 1'b1;
        end else if (!req_exp && !waiting && size_before > 0) begin
            req_exp = 1'b1;
        end
    endtask

    task automatic idle(input bit rdy, input bit vld);
        step(1'b0, 32'h0, '0, rdy, vld, 32'h0);
    endtask

    task automatic do_reset(input int n);
        rst             = 1'b1;
        bus.push_valid  = 1'b0;
        bus.push_addr   = '0;
        bus.push_data   = '0;
        bus.wr_rdy      = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.lookup_addr = '0;
        repeat (n) @(posedge clk);
        #1;
        rst     = 1'b0;
        q.delete();
        req_exp = 1'b0;
        waiting = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || req_exp || waiting) && n < 200) begin
            idle(1'b1, 1'b1);
            n++;
        end
        chk("drain_timeout", LW'(n < 200), LW'(1));
        chk("drained_count", LW'(bus.count), LW'(0));
    endtask

    initial begin
        logic [LW-1:0] a, b, c;
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h100, 32'h200, 32'h300, 32'h400};

        do_reset(2);
        chk("rst_wr_addr", LW'(bus.wr_addr), LW'(0));
        chk("rst_wr_data", bus.wr_data, LW'(0));
        chk("rst_ready", LW'(bus.push_ready), LW'(1));
        chk("rst_count", LW'(bus.count), LW'(0));

        // single line: request two cycles after the push, gone after wr_valid
        step(1'b1, 32'h1000_0040, LW'(32'hDEAD), 1'b1, 1'b0, 32'h1000_0040);
        idle(1'b1, 1'b0);
        chk("single_req", LW'(bus.wr_req), LW'(1));
        chk("single_addr", LW'(bus.wr_addr), LW'(32'h1000_0040));
        chk("single_data", bus.wr_data, LW'(32'hDEAD));
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk("single_count", LW'(bus.count), LW'(0));
        chk("single_empty", LW'(bus.empty), LW'(1));

        // fill to full with the slave stalled, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, exp_addr[i], {4{exp_addr[i]}}, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h500, {4{32'h500}}, 1'b0, 1'b0, 32'h0);
        chk("full_ready", LW'(bus.push_ready), LW'(0));
        chk("full_count", LW'(bus.count), LW'(4));
        chk("full_head", LW'(bus.wr_addr), LW'(32'h100));
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", LW'(bus.wr_addr), LW'(exp_addr[i]));
            idle(1'b1, 1'b0);
            idle(1'b0, 1'b1);
        end
        chk("drain_empty", LW'(bus.empty), LW'(1));

        // coalescing behind an in-flight line
        a = rnd_data();
        b = rnd_data();
        step(1'b1, 32'h100, rnd_data(), 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h200, a, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h300, rnd_data(), 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h200, b, 1'b0, 1'b0, 32'h204);
        chk("coal_count", LW'(bus.count), LW'(3));
        bus.lookup_addr = 32'h204;
        #1;
        chk("coal_hit", LW'(bus.lookup_hit), LW'(1));
        chk("coal_data", bus.lookup_data, b);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        chk("coal_wr_addr", LW'(bus.wr_addr), LW'(32'h200));
        chk("coal_wr_data", bus.wr_data, b);
        drain();

        // re-dirtying the line that is waiting for completion
        c = rnd_data();
        step(1'b1, 32'h100, rnd_data(), 1'b0, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        step(1'b1, 32'h100, c, 1'b0, 1'b0, 32'h100);
        chk("redirty_count", LW'(bus.count), LW'(2));
        bus.lookup_addr = 32'h108;
        #1;
        chk("redirty_hit", LW'(bus.lookup_hit), LW'(1));
        chk("redirty_data", bus.lookup_data, c);
        idle(1'b0, 1'b1);
        chk("redirty_wr_addr", LW'(bus.wr_addr), LW'(32'h100));
        chk("redirty_wr_data", bus.wr_data, c);
        drain();

        // reset while waiting with three lines queued
        for (int i = 1; i <= 3; i++) step(1'b1, 32'h10 * i, rnd_data(), 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        chk("prerst_count", LW'(bus.count), LW'(3));
        do_reset(1);
        bus.lookup_addr = 32'h20;
        #1;
        chk("midrst_req", LW'(bus.wr_req), LW'(0));
        chk("midrst_empty", LW'(bus.empty), LW'(1));
        chk("midrst_hit", LW'(bus.lookup_hit), LW'(0));
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);

        // random traffic over a handful of lines to provoke coalescing and forwarding
        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 1) == 1, rnd_addr(), rnd_data(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, rnd_addr());
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
